// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decoded bundle into EX, inserts bubbles on
// load-use hazards and flushes, freezes on downstream hold, and counts bubbles.
package id_ex_pkg;
  typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_op_t;
  typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMRD, WRSRC_PC4} reg_wr_src_t;
  typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} alu_src1_t;
  typedef enum logic [1:0] {SRC2_REG2, SRC2_IMM, SRC2_FOUR} alu_src2_t;
  typedef enum logic [3:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                            ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU} alu_op_t;
  typedef enum logic [3:0] {MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
                            MEM_SB, MEM_SH, MEM_SW} mem_op_t;
endpackage

module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_reg_do_write_ctrl,
  input  logic             id_mem_do_write_ctrl,
  input  logic             id_mem_do_read_ctrl,
  input  logic             id_do_branch,
  input  logic             id_do_jump,
  input  logic [2:0]       id_comp_ctrl,
  input  logic [1:0]       id_reg_wr_src_ctrl,
  input  logic [1:0]       id_alu_op1_ctrl,
  input  logic [1:0]       id_alu_op2_ctrl,
  input  logic [3:0]       id_alu_ctrl,
  input  logic [3:0]       id_mem_ctrl,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_do_write_ctrl,
  output logic             ex_mem_do_write_ctrl,
  output logic             ex_mem_do_read_ctrl,
  output logic             ex_do_branch,
  output logic             ex_do_jump,
  output logic [2:0]       ex_comp_ctrl,
  output logic [1:0]       ex_reg_wr_src_ctrl,
  output logic [1:0]       ex_alu_op1_ctrl,
  output logic [1:0]       ex_alu_op2_ctrl,
  output logic [3:0]       ex_alu_ctrl,
  output logic [3:0]       ex_mem_ctrl,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_we;
    logic            mem_we;
    logic            mem_re;
    logic            branch;
    logic            jump;
    logic [2:0]      comp;
    logic [1:0]      wr_src;
    logic [1:0]      src1;
    logic [1:0]      src2;
    logic [3:0]      alu;
    logic [3:0]      mem;
  } stage_t;

  // Bubbles keep whatever data arrives but force every control field to its idle value.
  function automatic stage_t idle_ctrl(input stage_t s);
    stage_t r;
    r        = s;
    r.reg_we = 1'b0;
    r.mem_we = 1'b0;
    r.mem_re = 1'b0;
    r.branch = 1'b0;
    r.jump   = 1'b0;
    r.comp   = BR_NOP;
    r.wr_src = WRSRC_ALURES;
    r.src1   = SRC1_REG1;
    r.src2   = SRC2_REG2;
    r.alu    = ALU_NOP;
    r.mem    = MEM_NOP;
    return r;
  endfunction

  stage_t           ex_q, ex_d, id_s;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  always_comb begin
    id_s.pc       = id_pc;
    id_s.rs1_data = id_rs1_data;
    id_s.rs2_data = id_rs2_data;
    id_s.imm      = id_imm;
    id_s.rs1      = id_rs1;
    id_s.rs2      = id_rs2;
    id_s.rd       = id_rd;
    id_s.reg_we   = id_reg_do_write_ctrl;
    id_s.mem_we   = id_mem_do_write_ctrl;
    id_s.mem_re   = id_mem_do_read_ctrl;
    id_s.branch   = id_do_branch;
    id_s.jump     = id_do_jump;
    id_s.comp     = id_comp_ctrl;
    id_s.wr_src   = id_reg_wr_src_ctrl;
    id_s.src1     = id_alu_op1_ctrl;
    id_s.src2     = id_alu_op2_ctrl;
    id_s.alu      = id_alu_ctrl;
    id_s.mem      = id_mem_ctrl;
  end

  // x0 is never a real dependency, so a load into x0 cannot cause a stall.
  assign lu = id_valid & valid_q & ex_q.mem_re & (ex_q.rd != 5'd0) &
              ((id_uses_rs1 & (id_rs1 == ex_q.rd)) | (id_uses_rs2 & (id_rs2 == ex_q.rd)));

  assign stall_id = hold | (lu & ~flush);

  always_comb begin
    ex_d    = ex_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (!hold) begin
      if (flush | lu) begin
        ex_d    = idle_ctrl(id_s);
        valid_d = 1'b0;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        ex_d    = id_s;
        valid_d = id_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q    <= idle_ctrl(stage_t'('0));
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid             = valid_q;
  assign ex_pc                = ex_q.pc;
  assign ex_rs1_data          = ex_q.rs1_data;
  assign ex_rs2_data          = ex_q.rs2_data;
  assign ex_imm               = ex_q.imm;
  assign ex_rs1               = ex_q.rs1;
  assign ex_rs2               = ex_q.rs2;
  assign ex_rd                = ex_q.rd;
  assign ex_reg_do_write_ctrl = ex_q.reg_we;
  assign ex_mem_do_write_ctrl = ex_q.mem_we;
  assign ex_mem_do_read_ctrl  = ex_q.mem_re;
  assign ex_do_branch         = ex_q.branch;
  assign ex_do_jump           = ex_q.jump;
  assign ex_comp_ctrl         = ex_q.comp;
  assign ex_reg_wr_src_ctrl   = ex_q.wr_src;
  assign ex_alu_op1_ctrl      = ex_q.src1;
  assign ex_alu_op2_ctrl      = ex_q.src2;
  assign ex_alu_ctrl          = ex_q.alu;
  assign ex_mem_ctrl          = ex_q.mem;
  assign bubble_count         = cnt_q;

endmodule
